// File: rtl/motor_pwm_driver_if.sv
// Command and pin bundle between direction control (master) and the
// H-bridge PWM driver (slave) for the two motor channels A and B.
interface motor_pwm_driver_if;
   logic [1:0] DutyCycleA;
   logic [1:0] DutyCycleB;
   logic       FWDA;
   logic       BWDA;
   logic       FWDB;
   logic       BWDB;
   logic       IN1A;
   logic       IN2A;
   logic       IN1B;
   logic       IN2B;
   logic       ENA;
   logic       ENB;
   logic       DeadA;
   logic       DeadB;

   modport master (
      output DutyCycleA, DutyCycleB, FWDA, BWDA, FWDB, BWDB,
      input  IN1A, IN2A, IN1B, IN2B, ENA, ENB, DeadA, DeadB
   );

   modport slave (
      input  DutyCycleA, DutyCycleB, FWDA, BWDA, FWDB, BWDB,
      output IN1A, IN2A, IN1B, IN2B, ENA, ENB, DeadA, DeadB
   );
endinterface

// File: rtl/motor_pwm_driver.sv
// Two-channel H-bridge driver: shared-period PWM with period-aligned duty
// updates and a fixed bridge-off dead-time on every reversal or stop.
module motor_pwm_driver #(
   parameter int PERIOD      = 4000,
   parameter int DEAD_CYCLES = 50000
) (
   input logic                clk,
   input logic                rst_n,
   motor_pwm_driver_if.slave  bus
);
   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int TW = $clog2(PERIOD + 1);
   localparam int DW = $clog2(DEAD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
   localparam logic [TW-1:0] QUARTER   = TW'(PERIOD / 4);
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {ST_STOP, ST_FWD, ST_REV, ST_DEAD} state_t;
   typedef enum logic [1:0] {CMD_STOP, CMD_FWD, CMD_REV} cmd_t;

   // Both direction bits set is an illegal request and must never drive.
   function automatic cmd_t decode_cmd(input logic fwd, input logic bwd);
      cmd_t cmd;
      case ({fwd, bwd})
         2'b10:   cmd = CMD_FWD;
         2'b01:   cmd = CMD_REV;
         default: cmd = CMD_STOP;
      endcase
      return cmd;
   endfunction

   function automatic logic [TW-1:0] thr_of(input logic [1:0] code);
      logic [TW-1:0] thr;
      case (code)
         2'b00:   thr = QUARTER;
         2'b01:   thr = QUARTER + QUARTER;
         2'b10:   thr = QUARTER + QUARTER + QUARTER;
         2'b11:   thr = TW'(PERIOD);
         default: thr = QUARTER;
      endcase
      return thr;
   endfunction

   logic [1:0][1:0] duty_s;
   logic [1:0]      fwd_s;
   logic [1:0]      bwd_s;

   assign duty_s = {bus.DutyCycleB, bus.DutyCycleA};
   assign fwd_s  = {bus.FWDB, bus.FWDA};
   assign bwd_s  = {bus.BWDB, bus.BWDA};

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nx_s;
   logic          wrap_s;

   // Shared free-running period counter, next value.
   always_comb begin
      wrap_s = (cnt_r == CNT_LAST);
      if (wrap_s) begin
         cnt_nx_s = {CW{1'b0}};
      end else begin
         cnt_nx_s = cnt_r + CW'(1);
      end
   end

   // Period counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else begin
         cnt_r <= cnt_nx_s;
      end
   end

   for (genvar ch = 0; ch < 2; ch++) begin : ch_g
      state_t        state_r;
      state_t        state_nx_s;
      cmd_t          cmd_s;
      logic [DW-1:0] dcnt_r;
      logic [DW-1:0] dcnt_nx_s;
      logic [TW-1:0] thr_r;
      logic [TW-1:0] thr_nx_s;
      logic          drive_s;
      logic          in1_r;
      logic          in2_r;
      logic          en_r;
      logic          dead_r;

      // Channel FSM next state; threshold only reloads at the period wrap.
      always_comb begin
         cmd_s      = decode_cmd(fwd_s[ch], bwd_s[ch]);
         state_nx_s = state_r;
         dcnt_nx_s  = dcnt_r;
         if (wrap_s) begin
            thr_nx_s = thr_of(duty_s[ch]);
         end else begin
            thr_nx_s = thr_r;
         end
         case (state_r)
            ST_STOP: begin
               case (cmd_s)
                  CMD_FWD: state_nx_s = ST_FWD;
                  CMD_REV: state_nx_s = ST_REV;
                  default: state_nx_s = ST_STOP;
               endcase
            end
            ST_FWD: begin
               if (cmd_s != CMD_FWD) begin
                  state_nx_s = ST_DEAD;
                  dcnt_nx_s  = DEAD_LOAD;
               end else begin
                  state_nx_s = ST_FWD;
               end
            end
            ST_REV: begin
               if (cmd_s != CMD_REV) begin
                  state_nx_s = ST_DEAD;
                  dcnt_nx_s  = DEAD_LOAD;
               end else begin
                  state_nx_s = ST_REV;
               end
            end
            ST_DEAD: begin
               if (dcnt_r == {DW{1'b0}}) begin
                  case (cmd_s)
                     CMD_FWD: state_nx_s = ST_FWD;
                     CMD_REV: state_nx_s = ST_REV;
                     default: state_nx_s = ST_STOP;
                  endcase
               end else begin
                  dcnt_nx_s = dcnt_r - DW'(1);
               end
            end
            default: state_nx_s = ST_STOP;
         endcase
         drive_s = (state_nx_s == ST_FWD) || (state_nx_s == ST_REV);
      end

      // State and pins, decoded from the next state so pins lag inputs by one edge.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_r <= ST_STOP;
            dcnt_r  <= {DW{1'b0}};
            thr_r   <= QUARTER;
            in1_r   <= 1'b0;
            in2_r   <= 1'b0;
            en_r    <= 1'b0;
            dead_r  <= 1'b0;
         end else begin
            state_r <= state_nx_s;
            dcnt_r  <= dcnt_nx_s;
            thr_r   <= thr_nx_s;
            in1_r   <= (state_nx_s == ST_FWD);
            in2_r   <= (state_nx_s == ST_REV);
            en_r    <= drive_s && (TW'(cnt_nx_s) < thr_nx_s);
            dead_r  <= (state_nx_s == ST_DEAD);
         end
      end
   end

   assign bus.IN1A  = ch_g[0].in1_r;
   assign bus.IN2A  = ch_g[0].in2_r;
   assign bus.ENA   = ch_g[0].en_r;
   assign bus.DeadA = ch_g[0].dead_r;
   assign bus.IN1B  = ch_g[1].in1_r;
   assign bus.IN2B  = ch_g[1].in2_r;
   assign bus.ENB   = ch_g[1].en_r;
   assign bus.DeadB = ch_g[1].dead_r;
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with PERIOD=8 and DEAD_CYCLES=4.
module tb_motor_pwm_driver;
   logic clk = 1'b0;
   logic rst_n;
   int   total  = 0;
   int   passed = 0;
   int   failed = 0;
   int   c      = 0;
   int   h;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   motor_pwm_driver_if bus();

   motor_pwm_driver #(.PERIOD(8), .DEAD_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // c mirrors the expected period counter after each edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      c = rst_n ? (c + 1) % 8 : 0;
   endtask

   task automatic wait_c0();
      for (int i = 0; i < 8 && c != 0; i++) tick();
   endtask

   task automatic measure(output int highs);
      highs = 0;
      for (int i = 0; i < 8; i++) begin
         highs += int'(bus.ENA);
         if (i < 7) tick();
      end
   endtask

   function automatic logic [31:0] pins_a();
      return 32'({bus.IN1A, bus.IN2A, bus.ENA, bus.DeadA});
   endfunction

   function automatic logic [31:0] pins_b();
      return 32'({bus.IN1B, bus.IN2B, bus.ENB, bus.DeadB});
   endfunction

   function automatic logic [31:0] dir_a();
      return 32'({bus.IN1A, bus.IN2A, bus.DeadA});
   endfunction

   function automatic logic [31:0] dir_b();
      return 32'({bus.IN1B, bus.IN2B, bus.DeadB});
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         chk("no_shoot_a", 32'(bus.IN1A & bus.IN2A), 32'd0);
         chk("no_shoot_b", 32'(bus.IN1B & bus.IN2B), 32'd0);
      end
   end

   initial begin
      rst_n = 1'b0;
      bus.DutyCycleA = 2'b00;
      bus.DutyCycleB = 2'b00;
      bus.FWDA = 1'b1;
      bus.BWDA = 1'b0;
      bus.FWDB = 1'b0;
      bus.BWDB = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_pins_a", pins_a(), 32'h0);
         chk("rst_pins_b", pins_b(), 32'h0);
         chk("rst_cnt", 32'(dut.cnt_r), 32'd0);
      end
      mon_en = 1'b1;

      rst_n = 1'b1;
      tick();
      chk("first_edge_a", pins_a(), 32'hA);

      for (int d = 0; d < 4; d++) begin
         bus.DutyCycleA = 2'(d);
         tick();
         wait_c0();
         chk("duty_first_high", 32'(bus.ENA), 32'd1);
         measure(h);
         chk("duty_high_count", 32'(h), 32'((d + 1) * 2));
      end

      bus.DutyCycleA = 2'b00;
      tick();
      h = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) bus.DutyCycleA = 2'b10;
         h += int'(bus.ENA);
         if (i < 7) tick();
      end
      chk("midchange_cur_period", 32'(h), 32'd2);
      tick();
      measure(h);
      chk("midchange_next_period", 32'(h), 32'd6);

      bus.FWDA = 1'b0;
      bus.BWDA = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rev_dead_a", pins_a(), 32'h1);
      end
      tick();
      chk("rev_in2_a", dir_a(), 32'h2);

      bus.FWDB = 1'b1;
      bus.BWDB = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("illegal_stop_b", pins_b(), 32'h0);
         chk("a_unaffected", dir_a(), 32'h2);
      end
      bus.BWDB = 1'b0;
      tick();
      chk("fwd_b", dir_b(), 32'h4);
      bus.BWDB = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("illegal_dead_b", pins_b(), 32'h1);
         chk("a_unaffected", dir_a(), 32'h2);
      end
      tick();
      chk("illegal_to_stop_b", pins_b(), 32'h0);
      tick();
      chk("illegal_stays_stop_b", pins_b(), 32'h0);

      bus.BWDA = 1'b0;
      tick();
      tick();
      chk("middead_pins_a", pins_a(), 32'h1);
      chk("middead_dcnt", 32'(dut.ch_g[0].dcnt_r), 32'd2);
      rst_n = 1'b0;
      bus.BWDA = 1'b1;
      tick();
      chk("middead_rst_a", pins_a(), 32'h0);
      chk("middead_rst_b", pins_b(), 32'h0);
      chk("middead_rst_cnt", 32'(dut.cnt_r), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_rev_a", pins_a(), 32'h6);
      tick();
      chk("post_rst_thr_a", pins_a(), 32'h4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
